mem_responder: RTL and testbench

//  Multi-cycle, fully pipelined word memory that serves requests from the CPU

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_req_pipe.sv | 85 ++++++++
 rtl/mem_responder.sv | 76 +++++++
 tb/tb_mem_responder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants and encodings for the pipelined word memory responder.
package mem_pkg;

    localparam int MEM_ADDR_W     = 16;
    localparam int MEM_DATA_W     = 16;
    localparam int MEM_DEPTH_LOG2 = 10;
    localparam int MEM_LATENCY    = 4;

    localparam logic MEM_RD = 1'b0;
    localparam logic MEM_WR = 1'b1;

    typedef enum logic {
        STG_EMPTY = 1'b0,
        STG_FULL  = 1'b1
    } stage_st_t;

endpackage

// File: rtl/mem_req_pipe.sv
// Request record shift register feeding the memory commit point.
//
// state     | meaning
// STG_EMPTY | stage holds no request
// STG_FULL  | stage holds a live request record
module mem_req_pipe
    import mem_pkg::*;
#(
    parameter int LATENCY = MEM_LATENCY,
    parameter int IDX_W   = MEM_DEPTH_LOG2,
    parameter int DATA_W  = MEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_wr,
    input  logic [IDX_W-1:0]  in_idx,
    input  logic [DATA_W-1:0] in_wdata,
    output logic              out_valid,
    output logic              out_wr,
    output logic [IDX_W-1:0]  out_idx,
    output logic [DATA_W-1:0] out_wdata,
    output logic              any_valid
);

    // The commit edge plus the response register account for one cycle of
    // latency, so only LATENCY-1 stages are registered here.
    localparam int DEPTH = LATENCY - 1;

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;

            assign out_valid = in_valid;
            assign out_wr    = in_wr;
            assign out_idx   = in_idx;
            assign out_wdata = in_wdata;
            assign any_valid = 1'b0;
        end else begin : g_stages
            stage_st_t         st      [DEPTH];
            logic              wr_q    [DEPTH];
            logic [IDX_W-1:0]  idx_q   [DEPTH];
            logic [DATA_W-1:0] wdata_q [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        st[i] <= STG_EMPTY;
                    end
                end else begin
                    st[0] <= in_valid ? STG_FULL : STG_EMPTY;
                    for (int i = 1; i < DEPTH; i++) begin
                        st[i] <= (st[i-1] == STG_FULL) ? STG_FULL : STG_EMPTY;
                    end
                end
            end

            // Payload is qualified by the stage state, so it needs no reset.
            always_ff @(posedge clk) begin
                wr_q[0]    <= in_wr;
                idx_q[0]   <= in_idx;
                wdata_q[0] <= in_wdata;
                for (int i = 1; i < DEPTH; i++) begin
                    wr_q[i]    <= wr_q[i-1];
                    idx_q[i]   <= idx_q[i-1];
                    wdata_q[i] <= wdata_q[i-1];
                end
            end

            always_comb begin
                any_valid = 1'b0;
                for (int i = 0; i < DEPTH; i++) begin
                    any_valid = any_valid | (st[i] == STG_FULL);
                end
            end

            assign out_valid = (st[DEPTH-1] == STG_FULL);
            assign out_wr    = wr_q[DEPTH-1];
            assign out_idx   = idx_q[DEPTH-1];
            assign out_wdata = wdata_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency, fully pipelined word memory; one request per cycle, in-order
// completion with wr_done / rsp_valid pulses.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int DATA_W     = MEM_DATA_W,
    parameter int DEPTH_LOG2 = MEM_DEPTH_LOG2,
    parameter int LATENCY    = MEM_LATENCY
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              wr_done,
    output logic              busy
);

    logic                  accept;
    logic                  fin_valid;
    logic                  fin_wr;
    logic [DEPTH_LOG2-1:0] fin_idx;
    logic [DATA_W-1:0]     fin_wdata;
    logic [DATA_W-1:0]     mem [2**DEPTH_LOG2];

    // Byte-lane bit and bits above the array window alias away.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[ADDR_W-1:DEPTH_LOG2+1], req_addr[0]};

    assign req_ready = rst_n;
    assign accept    = req_valid & rst_n;

    mem_req_pipe #(
        .LATENCY (LATENCY),
        .IDX_W   (DEPTH_LOG2),
        .DATA_W  (DATA_W)
    ) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (accept),
        .in_wr     (req_wr),
        .in_idx    (req_addr[DEPTH_LOG2:1]),
        .in_wdata  (req_wdata),
        .out_valid (fin_valid),
        .out_wr    (fin_wr),
        .out_idx   (fin_idx),
        .out_wdata (fin_wdata),
        .any_valid (busy)
    );

    always_ff @(posedge clk) begin
        if (fin_valid && (fin_wr == MEM_WR)) begin
            mem[fin_idx] <= fin_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            wr_done   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= fin_valid && (fin_wr == MEM_RD);
            wr_done   <= fin_valid && (fin_wr == MEM_WR);
            if (fin_valid && (fin_wr == MEM_RD)) begin
                rsp_rdata <= mem[fin_idx];
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed checks of mem_responder at LATENCY=4 plus a LATENCY=1 instance.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        req_valid, req_wr, req_ready;
    logic [15:0] req_addr, req_wdata;
    logic        rsp_valid, wr_done, busy;
    logic [15:0] rsp_rdata;

    logic        r1_valid, r1_wr, r1_ready;
    logic [15:0] r1_addr, r1_wdata;
    logic        r1_rsp_valid, r1_wr_done, r1_busy;
    logic [15:0] r1_rdata;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_responder u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .wr_done   (wr_done),
        .busy      (busy)
    );

    mem_responder #(.LATENCY(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (r1_valid),
        .req_wr    (r1_wr),
        .req_addr  (r1_addr),
        .req_wdata (r1_wdata),
        .req_ready (r1_ready),
        .rsp_valid (r1_rsp_valid),
        .rsp_rdata (r1_rdata),
        .wr_done   (r1_wr_done),
        .busy      (r1_busy)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic [15:0] a, input logic [15:0] d);
        req_valid = v;
        req_wr    = w;
        req_addr  = a;
        req_wdata = d;
    endtask

    task automatic drive1(input logic v, input logic w, input logic [15:0] a, input logic [15:0] d);
        r1_valid = v;
        r1_wr    = w;
        r1_addr  = a;
        r1_wdata = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 16'h0, 16'h0);
        drive1(0, 0, 16'h0, 16'h0);
        tick();
        tick();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_wr_done", wr_done, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();
        chk("req_ready", req_ready, 1);

        // 1: basic write then read
        for (int c = 0; c <= 10; c++) begin
            if (c == 0)      drive(1, 1, 16'h0010, 16'h1234);
            else if (c == 5) drive(1, 0, 16'h0010, 16'h0000);
            else             drive(0, 0, 16'h0, 16'h0);
            chk($sformatf("t1_wr_done@%0d", c), wr_done, (c == 4));
            chk($sformatf("t1_rsp_valid@%0d", c), rsp_valid, (c == 9));
            chk($sformatf("t1_busy@%0d", c), busy, ((c >= 1 && c <= 3) || (c >= 6 && c <= 8)));
            if (c == 9) chk("t1_rdata", rsp_rdata, 16'h1234);
            tick();
        end

        // 2: hazard ordering around a write to 0x0020
        drive(1, 1, 16'h0020, 16'h1111);
        tick();
        drive(0, 0, 16'h0, 16'h0);
        repeat (6) tick();
        for (int c = -1; c <= 6; c++) begin
            if (c == -1)     drive(1, 0, 16'h0020, 16'h0);
            else if (c == 0) drive(1, 1, 16'h0020, 16'hBEEF);
            else if (c == 1) drive(1, 0, 16'h0020, 16'h0);
            else             drive(0, 0, 16'h0, 16'h0);
            chk($sformatf("t2_rsp_valid@%0d", c), rsp_valid, (c == 3 || c == 5));
            chk($sformatf("t2_wr_done@%0d", c), wr_done, (c == 4));
            if (c == 3) chk("t2_old_data", rsp_rdata, 16'h1111);
            if (c == 5) chk("t2_new_data", rsp_rdata, 16'hBEEF);
            tick();
        end

        // 3: preload then back-to-back reads
        for (int c = 0; c <= 33; c++) begin
            if (c < 8)                 drive(1, 1, 16'(2 * c), 16'(16'h1000 + c));
            else if (c >= 20 && c < 28) drive(1, 0, 16'(2 * (c - 20)), 16'h0);
            else                       drive(0, 0, 16'h0, 16'h0);
            if (c < 19) begin
                chk($sformatf("t3_pre_wr_done@%0d", c), wr_done, (c >= 4 && c <= 11));
            end else begin
                chk($sformatf("t3_rsp_valid@%0d", c), rsp_valid, (c >= 24 && c <= 31));
                chk($sformatf("t3_busy@%0d", c), busy, (c >= 21 && c <= 30));
                if (c >= 24 && c <= 31) chk($sformatf("t3_rdata@%0d", c), rsp_rdata, 16'h1000 + (c - 24));
            end
            tick();
        end

        // 4: aliasing and byte-offset alignment
        for (int c = 0; c <= 7; c++) begin
            if (c == 0)      drive(1, 1, 16'h0802, 16'hA5A5);
            else if (c == 1) drive(1, 0, 16'h0002, 16'h0);
            else if (c == 2) drive(1, 0, 16'h0803, 16'h0);
            else             drive(0, 0, 16'h0, 16'h0);
            chk($sformatf("t4_rsp_valid@%0d", c), rsp_valid, (c == 5 || c == 6));
            chk($sformatf("t4_wr_done@%0d", c), wr_done, (c == 4));
            if (c == 5 || c == 6) chk($sformatf("t4_rdata@%0d", c), rsp_rdata, 16'hA5A5);
            tick();
        end

        // 5: reset while a write is in flight
        drive(1, 1, 16'h0040, 16'h0A0A);
        tick();
        drive(0, 0, 16'h0, 16'h0);
        repeat (6) tick();
        for (int c = 0; c <= 12; c++) begin
            if (c == 0)      drive(1, 1, 16'h0040, 16'h5555);
            else if (c == 7) drive(1, 0, 16'h0040, 16'h0);
            else             drive(0, 0, 16'h0, 16'h0);
            if (c == 2) begin
                chk("t5_busy_before_rst", busy, 1);
                rst_n = 1'b0;
                #1;
            end
            if (c == 3) rst_n = 1'b1;
            if (c >= 2 && c <= 6) begin
                chk($sformatf("t5_busy@%0d", c), busy, 0);
                chk($sformatf("t5_rsp_valid@%0d", c), rsp_valid, 0);
                chk($sformatf("t5_wr_done@%0d", c), wr_done, 0);
            end
            if (c == 11) begin
                chk("t5_rsp_valid", rsp_valid, 1);
                chk("t5_rdata", rsp_rdata, 16'h0A0A);
            end
            tick();
        end

        // 6: LATENCY=1 instance
        for (int c = 0; c <= 3; c++) begin
            if (c == 0)      drive1(1, 1, 16'h0100, 16'h7E57);
            else if (c == 1) drive1(1, 0, 16'h0100, 16'h0);
            else             drive1(0, 0, 16'h0, 16'h0);
            chk($sformatf("t6_wr_done@%0d", c), r1_wr_done, (c == 1));
            chk($sformatf("t6_rsp_valid@%0d", c), r1_rsp_valid, (c == 2));
            chk($sformatf("t6_busy@%0d", c), r1_busy, 0);
            if (c == 2) chk("t6_rdata", r1_rdata, 16'h7E57);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
